gate_vector_decoder: RTL and testbench

- Receiving end of the seven-output two-input gate bank: accepts the packed gate-output vector {xnor,xor,not,nor,or,nand,and} and recovers the operand pair (a,b).
- Re-encodes the recovered pair and flags any vector that no legal (a,b) can produce.
- Tracks error statistics and a fault state machine.
- Sits between a gate bank (or a capture register fed from one) and a monitor or logging stage, with valid/ready handshakes on both sides.

---
 rtl/gate_pkg.sv | 31 +++
 rtl/gate_bank_encode.sv | 19 +
 rtl/gate_vector_decoder.sv | 119 +++++++++++
 tb/tb_gate_vector_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate-vector decoder: bit positions, FSM states, defaults.
package gate_pkg;
  localparam int GATE_W = 7;
  localparam int AND_I  = 0;
  localparam int NAND_I = 1;
  localparam int OR_I   = 2;
  localparam int NOR_I  = 3;
  localparam int NOT_I  = 4;
  localparam int XOR_I  = 5;
  localparam int XNOR_I = 6;

  localparam int CNT_W_DEF        = 8;
  localparam int FAULT_THRESH_DEF = 3;

  typedef enum logic [1:0] {OK, SUSPECT, FAULT} fsm_e;

  typedef struct packed {
    logic a;
    logic b;
  } pair_t;

  // Priority decode: and, then nor, then not(a), else the remaining pair.
  function automatic pair_t decode_pair(input logic [GATE_W-1:0] v);
    pair_t p;
    if (v[AND_I])      p = '{a: 1'b1, b: 1'b1};
    else if (v[NOR_I]) p = '{a: 1'b0, b: 1'b0};
    else if (!v[NOT_I]) p = '{a: 1'b1, b: 1'b0};
    else               p = '{a: 1'b0, b: 1'b1};
    return p;
  endfunction
endpackage

// File: rtl/gate_bank_encode.sv
// Combinational model of the two-input gate bank: (a,b) -> packed 7-bit output vector.
module gate_bank_encode
  import gate_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [GATE_W-1:0] vec_o
);
  always_comb begin
    vec_o         = '0;
    vec_o[AND_I]  = a_i & b_i;
    vec_o[NAND_I] = ~(a_i & b_i);
    vec_o[OR_I]   = a_i | b_i;
    vec_o[NOR_I]  = ~(a_i | b_i);
    vec_o[NOT_I]  = ~a_i;
    vec_o[XOR_I]  = a_i ^ b_i;
    vec_o[XNOR_I] = ~(a_i ^ b_i);
  end
endmodule

// File: rtl/gate_vector_decoder.sv
// Recovers (a,b) from a gate-bank vector, flags illegal vectors, tracks error stats/fault FSM.
// Define GATE_DEC_MASK_EN to add the registered err_mask output.
module gate_vector_decoder
  import gate_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FAULT_THRESH = FAULT_THRESH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [GATE_W-1:0] gate_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              a_out,
  output logic              b_out,
  output logic              vec_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              fault,
  input  logic              clr
`ifdef GATE_DEC_MASK_EN
  ,
  output logic [GATE_W-1:0] err_mask
`endif
);
  localparam logic [3:0] THR = 4'(FAULT_THRESH);

  logic              accept, bad;
  pair_t             dec;
  logic [GATE_W-1:0] enc;

  logic              out_valid_q, out_valid_d;
  pair_t             pair_q, pair_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [3:0]        cons_q, cons_d, cons_inc;
  fsm_e              state_q, state_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign dec      = decode_pair(gate_vec);
  assign bad      = (enc != gate_vec);
  assign cons_inc = (cons_q == 4'hF) ? cons_q : cons_q + 4'd1;

  gate_bank_encode u_enc (.a_i(dec.a), .b_i(dec.b), .vec_o(enc));

  always_comb begin
    out_valid_d = out_valid_q;
    pair_d      = pair_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      pair_d      = dec;
      err_d       = bad;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // clr overrides any accepted vector for counters and FSM, but not for output data.
  always_comb begin
    err_cnt_d = err_cnt_q;
    cons_d    = cons_q;
    state_d   = state_q;
    if (clr) begin
      err_cnt_d = '0;
      cons_d    = '0;
      state_d   = OK;
    end else if (accept) begin
      if (bad) begin
        err_cnt_d = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q
                                                 : err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        cons_d    = cons_inc;
        if (state_q != FAULT) state_d = (cons_inc >= THR) ? FAULT : SUSPECT;
      end else begin
        cons_d = '0;
        if (state_q == SUSPECT) state_d = OK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pair_q      <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      cons_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pair_q      <= pair_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      cons_q      <= cons_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OK;
    else        state_q <= state_d;
  end

`ifdef GATE_DEC_MASK_EN
  logic [GATE_W-1:0] mask_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mask_q <= '0;
    else if (accept) mask_q <= enc ^ gate_vec;
  end
  assign err_mask = mask_q;
`endif

  assign out_valid = out_valid_q;
  assign a_out     = pair_q.a;
  assign b_out     = pair_q.b;
  assign vec_err   = err_q;
  assign err_cnt   = err_cnt_q;
  assign fault     = (state_q == FAULT);
endmodule

// File: tb/tb_gate_vector_decoder.sv
// Bench for gate_vector_decoder: two configurations driven in lockstep against a behavioural model.
module tb_gate_vector_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b0, clr = 1'b0;
  logic [6:0] gate_vec = '0;

  logic       in_ready0, out_valid0, a0, b0, err0, fault0;
  logic [7:0] cnt0;
  logic       in_ready1, out_valid1, a1, b1, err1, fault1;
  logic [1:0] cnt1;
`ifdef GATE_DEC_MASK_EN
  logic [6:0] mask0, mask1;
`endif

  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  gate_vector_decoder #(.CNT_W(8), .FAULT_THRESH(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .gate_vec(gate_vec),
    .out_valid(out_valid0), .out_ready(out_ready), .a_out(a0), .b_out(b0), .vec_err(err0),
    .err_cnt(cnt0), .fault(fault0),
`ifdef GATE_DEC_MASK_EN
    .err_mask(mask0),
`endif
    .clr(clr));

  gate_vector_decoder #(.CNT_W(2), .FAULT_THRESH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .gate_vec(gate_vec),
    .out_valid(out_valid1), .out_ready(out_ready), .a_out(a1), .b_out(b1), .vec_err(err1),
    .err_cnt(cnt1), .fault(fault1),
`ifdef GATE_DEC_MASK_EN
    .err_mask(mask1),
`endif
    .clr(clr));

  // Behavioural model state, index 0 = dut0, 1 = dut1
  int   cnt_max [2] = '{255, 3};
  int   thr     [2] = '{3, 1};
  bit   m_ov [2], m_a [2], m_b [2], m_err [2], m_fault [2];
  int   m_cnt [2], m_cons [2];
  bit [6:0] m_mask [2];

  function automatic bit [6:0] genc(input bit a, input bit b);
    return {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ov[k] = 0; m_a[k] = 0; m_b[k] = 0; m_err[k] = 0; m_fault[k] = 0;
      m_cnt[k] = 0; m_cons[k] = 0; m_mask[k] = '0;
    end
  endtask

  task automatic model_step(input bit [6:0] v, input bit iv, input bit ordy, input bit c);
    bit acc, a, b, bad;
    for (int k = 0; k < 2; k++) begin
      acc = iv && (!m_ov[k] || ordy);
      if (v[0])       begin a = 1; b = 1; end
      else if (v[3])  begin a = 0; b = 0; end
      else if (!v[4]) begin a = 1; b = 0; end
      else            begin a = 0; b = 1; end
      bad = (genc(a, b) != v);
      if (acc) begin
        m_ov[k] = 1; m_a[k] = a; m_b[k] = b; m_err[k] = bad; m_mask[k] = genc(a, b) ^ v;
      end else if (ordy) m_ov[k] = 0;
      if (c) begin
        m_cnt[k] = 0; m_cons[k] = 0; m_fault[k] = 0;
      end else if (acc) begin
        if (bad) begin
          if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
          if (m_cons[k] < 15) m_cons[k]++;
          if (m_cons[k] >= thr[k]) m_fault[k] = 1;
        end else m_cons[k] = 0;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".ov0"},    out_valid0, m_ov[0]);
    chk({tag, ".a0"},     a0, m_a[0]);
    chk({tag, ".b0"},     b0, m_b[0]);
    chk({tag, ".err0"},   err0, m_err[0]);
    chk({tag, ".cnt0"},   cnt0, m_cnt[0]);
    chk({tag, ".fault0"}, fault0, m_fault[0]);
    chk({tag, ".ov1"},    out_valid1, m_ov[1]);
    chk({tag, ".cnt1"},   cnt1, m_cnt[1]);
    chk({tag, ".fault1"}, fault1, m_fault[1]);
`ifdef GATE_DEC_MASK_EN
    chk({tag, ".mask0"},  mask0, m_mask[0]);
    chk({tag, ".mask1"},  mask1, m_mask[1]);
`endif
  endtask

  task automatic step(input string tag, input bit [6:0] v, input bit iv, input bit ordy, input bit c);
    gate_vec = v; in_valid = iv; out_ready = ordy; clr = c;
    #1;
    chk({tag, ".in_ready0"}, in_ready0, !m_ov[0] || ordy);
    chk({tag, ".in_ready1"}, in_ready1, !m_ov[1] || ordy);
    @(posedge clk);
    model_step(v, iv, ordy, c);
    @(negedge clk);
    check_outs(tag);
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst.in_ready", in_ready0, 1);
    check_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // legal sweep
    for (int i = 0; i < 4; i++) step("legal", genc(i[1], i[0]), 1, 1, 0);
    // bad then good
    step("bad7f", 7'h7F, 1, 1, 0);
    step("good11", genc(1, 1), 1, 1, 0);
    // fault on third consecutive bad, sticky through legal vectors, then clr
    for (int i = 0; i < 3; i++) step("bad00", 7'h00, 1, 1, 0);
    for (int i = 0; i < 2; i++) step("sticky", genc(0, 1), 1, 1, 0);
    step("clr", genc(1, 0), 1, 1, 1);
    step("idle", 7'h00, 0, 1, 0);
    // backpressure
    step("bp_load", genc(0, 0), 1, 0, 0);
    for (int i = 0; i < 4; i++) step("bp_hold", 7'h7F, 1, 0, 0);
    step("bp_rel", genc(1, 1), 1, 1, 0);
    // saturation of the narrow counter
    for (int i = 0; i < 5; i++) step("sat", 7'h55, 1, 1, 0);
    step("mask4b", 7'h4B, 1, 1, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit [6:0] v;
      if ($urandom_range(0, 2) == 0) v = 7'($urandom);
      else v = genc(1'($urandom), 1'($urandom));
      step("rnd", v, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0);
    end

    // async reset with a held output and nonzero counters
    step("pre_a", 7'h00, 1, 1, 0);
    step("pre_b", 7'h00, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.ov0", out_valid0, 0);
    chk("arst.cnt0", cnt0, 0);
    chk("arst.fault0", fault0, 0);
    chk("arst.ov1", out_valid1, 0);
    chk("arst.in_ready", in_ready0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step("post", genc(0, 1), 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
